param_fifo: RTL and testbench

Parametrised synchronous FIFO: next-generation data buffer for single-clock streaming paths. Configurable width and depth, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. Sits between a producer and consumer in the same clock domain wherever rate decoupling is needed.

---
 rtl/param_fifo.sv | 124 ++++++++++++
 tb/tb_param_fifo.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// param_fifo -- parameterised single-clock FIFO.
//
// Purpose: rate-decoupling buffer between a producer and a consumer that
// share one clock. It provides an occupancy count, programmable
// almost-full/almost-empty flags, sticky overflow/underflow flags, a
// synchronous flush and a selectable read mode (registered or
// first-word-fall-through).
//
// Ports:
//   clk          single clock; all state updates on the rising edge
//   rst          asynchronous reset, active low
//   flush        synchronous clear of contents and error flags
//   wr_enb       write request; data_in is stored if the FIFO is not full
//   data_in      write data
//   rd_enb       read request; pops one word if the FIFO is not empty
//   data_out     read data (registered, or the head word when FWFT=1)
//   full/empty   count == DEPTH / count == 0
//   almost_full  count >= AF_THRESH
//   almost_empty count <= AE_THRESH
//   count        occupancy, 0..DEPTH
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
module param_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_enb,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       rd_enb,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
  localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);

  // Storage is deliberately not reset; pointers/count define validity.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_udf;

  logic w_wr_acc;
  logic w_rd_acc;

  // Flags come straight from the registered count: no lookahead.
  assign full         = (r_count == C_DEPTH);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

  // Flush masks both requests so a flush cycle neither stores nor pops.
  assign w_wr_acc = wr_enb & ~full  & ~flush;
  assign w_rd_acc = rd_enb & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (wr_enb && full)  r_ovf <= 1'b1;
      if (rd_enb && empty) r_udf <= 1'b1;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word presented combinationally; rd_enb acknowledges it.
      assign data_out = empty ? '0 : r_mem[r_rptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_dout;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_dout <= '0;
        else if (flush)    r_dout <= '0;
        else if (w_rd_acc) r_dout <= r_mem[r_rptr];
      end
      assign data_out = r_dout;
    end
  endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo. Two instances (registered read and
// FWFT) share the same stimulus; a queue-based model supplies expectations.
module tb_param_fifo;
  localparam int DW = 8;
  localparam int D  = 16;
  localparam int AF = 14;
  localparam int AE = 2;
  localparam int CW = $clog2(D) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic wr = 1'b0;
  logic rd = 1'b0;
  logic [DW-1:0] din = '0;

  logic [DW-1:0] dout0, dout1;
  logic full0, empty0, af0, ae0, ovf0, udf0;
  logic full1, empty1, af1, ae1, ovf1, udf1;
  logic [CW-1:0] cnt0, cnt1;

  param_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_enb(wr), .data_in(din), .rd_enb(rd),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(udf0));

  param_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_enb(wr), .data_in(din), .rd_enb(rd),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(udf1));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: contents as a queue, sticky flags, registered read word.
  logic [DW-1:0] q[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;
  logic [DW-1:0] m_d0 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    logic [DW-1:0] head;
    n = q.size();
    head = (n > 0) ? q[0] : '0;
    chk("count",        32'(cnt0),  32'(n));
    chk("full",         32'(full0), 32'(n == D));
    chk("empty",        32'(empty0), 32'(n == 0));
    chk("almost_full",  32'(af0),   32'(n >= AF));
    chk("almost_empty", 32'(ae0),   32'(n <= AE));
    chk("overflow",     32'(ovf0),  32'(m_ovf));
    chk("underflow",    32'(udf0),  32'(m_udf));
    chk("dout_std",     32'(dout0), 32'(m_d0));
    chk("fwft_count",   32'(cnt1),  32'(n));
    chk("fwft_flags",   32'({full1, empty1, af1, ae1, ovf1, udf1}),
        32'({n == D, n == 0, n >= AF, n <= AE, m_ovf, m_udf}));
    chk("dout_fwft",    32'(dout1), 32'(head));
  endtask

  // One clock: drive inputs, advance model at the edge, check 1 time unit later.
  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
    bit was_full, was_empty;
    wr = w; din = d; rd = r; flush = f;
    @(posedge clk);
    was_full  = (q.size() == D);
    was_empty = (q.size() == 0);
    if (f) begin
      q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_d0 = '0;
    end else begin
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_udf = 1'b1;
      if (r && !was_empty) m_d0 = q.pop_front();
      if (w && !was_full)  q.push_back(d);
    end
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0;
    check_all();
  endtask

  initial begin
    // Reset state
    #12;
    check_all();
    rst = 1'b1;
    cyc(0, 0, 0, 0);

    // Fill 0x01..0x10, then a 17th write overflows
    for (int i = 1; i <= 16; i++) cyc(1, DW'(i), 0, 0);
    cyc(1, 8'hEE, 0, 0);

    // Drain 16, then one extra read underflows; data_out holds 0x10
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("hold_last", 32'(dout0), 32'h10);
    cyc(0, 0, 0, 1);

    // Pointer wrap
    for (int i = 0; i < 10; i++) cyc(1, DW'($urandom), 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0);
    for (int i = 0; i < 16; i++) cyc(1, DW'(8'hA0 + i), 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);

    // Simultaneous wr+rd at count 5
    for (int i = 0; i < 5; i++) cyc(1, DW'($urandom), 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, DW'($urandom), 1, 0);
    // wr+rd at full: read wins, write dropped
    for (int i = 0; i < 11; i++) cyc(1, DW'($urandom), 0, 0);
    cyc(1, 8'h77, 1, 0);
    // wr+rd at empty: write wins, read rejected
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, 0);
    cyc(1, 8'h66, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);

    // FWFT presentation of a single word
    cyc(1, 8'h5A, 0, 0);
    chk("fwft_5a", 32'(dout1), 32'h5A);
    cyc(0, 0, 1, 0);
    chk("fwft_pop", 32'(dout1), 32'h0);

    // Count 7 with overflow set, then flush together with a write
    for (int i = 0; i < 17; i++) cyc(1, DW'($urandom), 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0);
    cyc(1, 8'h33, 0, 1);
    cyc(1, 8'h44, 0, 0);
    cyc(0, 0, 1, 0);

    // Randomised traffic with occasional flush
    for (int i = 0; i < 400; i++)
      cyc(bit'($urandom_range(0, 1)), DW'($urandom), bit'($urandom_range(0, 1)),
          ($urandom_range(0, 63) == 0));

    // Asynchronous reset mid-stream, observed before the next edge
    for (int i = 0; i < 6; i++) cyc(1, DW'($urandom), i[0], 0);
    #2;
    rst = 1'b0;
    #1;
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_d0 = '0;
    check_all();
    #2;
    rst = 1'b1;
    cyc(1, 8'hC3, 0, 0);
    cyc(0, 0, 1, 0);
    chk("post_reset_word", 32'(dout0), 32'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
